// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcode and sub-op encodings
// plus the retire-stage control state.
package cpu_pkg;

  localparam logic [3:0] OP_SUB  = 4'h0;
  localparam logic [3:0] OP_MOVL = 4'h8;
  localparam logic [3:0] OP_MOVH = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_MEM  = 4'hF;

  localparam logic [3:0] JMP_JZ  = 4'h0;
  localparam logic [3:0] JMP_JNZ = 4'h1;
  localparam logic [3:0] JMP_JS  = 4'h2;
  localparam logic [3:0] JMP_JNS = 4'h3;

  localparam logic [3:0] MEM_LD  = 4'h0;
  localparam logic [3:0] MEM_ST  = 4'h1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/retire_decode.sv
// Combinational decode of the execute-slot instruction: class, branch
// condition, register write value and the jump's next PC.
module retire_decode
  import cpu_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic [15:0] va,
  input  logic [15:0] vb,
  input  logic [15:0] vt,
  input  logic [15:0] ld_data,
  output logic        is_sub,
  output logic        is_movl,
  output logic        is_movh,
  output logic        is_jz,
  output logic        is_jnz,
  output logic        is_js,
  output logic        is_jns,
  output logic        is_ld,
  output logic        is_st,
  output logic        is_jmp,
  output logic        is_undef,
  output logic        writes_reg,
  output logic        taken,
  output logic [15:0] wdata,
  output logic [15:0] jump_target
);

  logic [3:0] op;
  logic [3:0] sub;
  logic [7:0] imm8;

  assign op   = inst[15:12];
  assign sub  = inst[7:4];
  assign imm8 = inst[11:4];

  assign is_sub  = (op == OP_SUB);
  assign is_movl = (op == OP_MOVL);
  assign is_movh = (op == OP_MOVH);
  assign is_jz   = (op == OP_JMP) && (sub == JMP_JZ);
  assign is_jnz  = (op == OP_JMP) && (sub == JMP_JNZ);
  assign is_js   = (op == OP_JMP) && (sub == JMP_JS);
  assign is_jns  = (op == OP_JMP) && (sub == JMP_JNS);
  assign is_ld   = (op == OP_MEM) && (sub == MEM_LD);
  assign is_st   = (op == OP_MEM) && (sub == MEM_ST);

  assign is_jmp     = is_jz | is_jnz | is_js | is_jns;
  assign writes_reg = is_sub | is_movl | is_movh | is_ld;
  // Anything outside the recognised classes (including unused jump and
  // memory sub-ops) is treated as a fault.
  assign is_undef   = ~(writes_reg | is_jmp | is_st);

  // Branch condition evaluated on r[a]; zero for non-jumps.
  always_comb begin
    taken = 1'b0;
    if (is_jz)  taken = (va == 16'h0000);
    if (is_jnz) taken = (va != 16'h0000);
    if (is_js)  taken = va[15];
    if (is_jns) taken = ~va[15];
  end

  // Register write value for the writing classes.
  always_comb begin
    wdata = 16'h0000;
    if (is_sub)  wdata = va - vb;
    if (is_movl) wdata = {{8{imm8[7]}}, imm8};
    if (is_movh) wdata = {imm8, vt[7:0]};
    if (is_ld)   wdata = ld_data;
  end

  assign jump_target = taken ? vt : (pc + 16'd1);

endmodule

// File: rtl/retire_stage.sv
// Retire stage: turns each accepted instruction into one cycle of
// registered architectural side effects, squashes the younger slots after
// a taken jump and parks the core in HALTED after an undefined opcode.
module retire_stage
  import cpu_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_x,
  input  logic        stall,
  input  logic [15:0] pc_x,
  input  logic [15:0] inst_x,
  input  logic [15:0] va_x,
  input  logic [15:0] vb_x,
  input  logic [15:0] vt_x,
  input  logic [15:0] ld_data_x,
  output logic        retired,
  output logic [15:0] pc_e,
  output logic        isSub_e,
  output logic        isMovl_e,
  output logic        isMovh_e,
  output logic        isJz_e,
  output logic        isJnz_e,
  output logic        isJs_e,
  output logic        isJns_e,
  output logic        isLd_e,
  output logic        isSt,
  output logic        reg_wen,
  output logic [3:0]  waddr,
  output logic [15:0] wdata,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        isJumping,
  output logic [15:0] jump_addr,
  output logic        print_valid,
  output logic [7:0]  print_char,
  output logic        halt
);

  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_DEPTH);

  logic        is_sub, is_movl, is_movh, is_jz, is_jnz, is_js, is_jns;
  logic        is_ld, is_st, is_jmp, is_undef, writes_reg, taken;
  logic [15:0] dec_wdata, jump_target;
  logic [3:0]  t;

  retire_decode u_decode (
    .pc          (pc_x),
    .inst        (inst_x),
    .va          (va_x),
    .vb          (vb_x),
    .vt          (vt_x),
    .ld_data     (ld_data_x),
    .is_sub      (is_sub),
    .is_movl     (is_movl),
    .is_movh     (is_movh),
    .is_jz       (is_jz),
    .is_jnz      (is_jnz),
    .is_js       (is_js),
    .is_jns      (is_jns),
    .is_ld       (is_ld),
    .is_st       (is_st),
    .is_jmp      (is_jmp),
    .is_undef    (is_undef),
    .writes_reg  (writes_reg),
    .taken       (taken),
    .wdata       (dec_wdata),
    .jump_target (jump_target)
  );

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       accept, retire_now, fault_now;

  assign t          = inst_x[3:0];
  assign accept     = valid_x & ~stall & (state_reg != HALTED);
  assign retire_now = accept & (state_reg == RUN) & ~is_undef;
  assign fault_now  = accept & (state_reg == RUN) & is_undef;

  // State and squash counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: the squash count only moves on accepted slots, so stalls
  // and bubbles never shorten the flush window.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (retire_now && taken) begin
          state_next = FLUSH;
          cnt_next   = FLUSH_CNT;
        end else if (fault_now) begin
          state_next = HALTED;
        end
      end
      FLUSH: begin
        if (accept) begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_next = RUN;
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  logic [8:0]  cls_next;
  logic        retired_next, reg_wen_next, mem_wen_next;
  logic        jumping_next, print_valid_next, halt_next;
  logic [15:0] pc_next, wdata_next, mem_addr_next, mem_data_next, jump_addr_next;
  logic [3:0]  waddr_next;
  logic [7:0]  print_char_next;

  // Output values for the next cycle: pulses are gated by retire, data
  // fields refresh only when their class retires and otherwise hold.
  always_comb begin
    retired_next     = retire_now;
    cls_next         = retire_now ? {is_sub, is_movl, is_movh, is_jz, is_jnz,
                                     is_js, is_jns, is_ld, is_st} : 9'd0;
    reg_wen_next     = retire_now & writes_reg & (t != 4'd0);
    print_valid_next = retire_now & writes_reg & (t == 4'd0);
    mem_wen_next     = retire_now & is_st;
    jumping_next     = retire_now & taken;
    halt_next        = halt | fault_now;
    pc_next          = (retire_now | fault_now) ? pc_x : pc_e;
    waddr_next       = (retire_now & writes_reg) ? t : waddr;
    wdata_next       = (retire_now & writes_reg) ? dec_wdata : wdata;
    print_char_next  = print_valid_next ? dec_wdata[7:0] : print_char;
    mem_addr_next    = mem_wen_next ? va_x : mem_addr;
    mem_data_next    = mem_wen_next ? vt_x : mem_data;
    jump_addr_next   = (retire_now & is_jmp) ? jump_target : jump_addr;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired     <= 1'b0;
      pc_e        <= 16'h0000;
      {isSub_e, isMovl_e, isMovh_e, isJz_e, isJnz_e,
       isJs_e, isJns_e, isLd_e, isSt} <= 9'd0;
      reg_wen     <= 1'b0;
      waddr       <= 4'd0;
      wdata       <= 16'h0000;
      mem_wen     <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_data    <= 16'h0000;
      isJumping   <= 1'b0;
      jump_addr   <= 16'h0000;
      print_valid <= 1'b0;
      print_char  <= 8'h00;
      halt        <= 1'b0;
    end else begin
      retired     <= retired_next;
      pc_e        <= pc_next;
      {isSub_e, isMovl_e, isMovh_e, isJz_e, isJnz_e,
       isJs_e, isJns_e, isLd_e, isSt} <= cls_next;
      reg_wen     <= reg_wen_next;
      waddr       <= waddr_next;
      wdata       <= wdata_next;
      mem_wen     <= mem_wen_next;
      mem_addr    <= mem_addr_next;
      mem_data    <= mem_data_next;
      isJumping   <= jumping_next;
      jump_addr   <= jump_addr_next;
      print_valid <= print_valid_next;
      print_char  <= print_char_next;
      halt        <= halt_next;
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage: directed scenarios followed by random traffic,
// every output compared each cycle against a behavioural model.
module tb_retire_stage;

  localparam int FD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_x = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] pc_x = '0, inst_x = '0, va_x = '0, vb_x = '0, vt_x = '0, ld_data_x = '0;

  logic        retired, isSub_e, isMovl_e, isMovh_e, isJz_e, isJnz_e, isJs_e, isJns_e, isLd_e, isSt;
  logic        reg_wen, mem_wen, isJumping, print_valid, halt;
  logic [15:0] pc_e, wdata, mem_addr, mem_data, jump_addr;
  logic [3:0]  waddr;
  logic [7:0]  print_char;

  always #5 clk = ~clk;

  retire_stage #(.FLUSH_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .valid_x(valid_x), .stall(stall),
    .pc_x(pc_x), .inst_x(inst_x), .va_x(va_x), .vb_x(vb_x), .vt_x(vt_x),
    .ld_data_x(ld_data_x),
    .retired(retired), .pc_e(pc_e),
    .isSub_e(isSub_e), .isMovl_e(isMovl_e), .isMovh_e(isMovh_e),
    .isJz_e(isJz_e), .isJnz_e(isJnz_e), .isJs_e(isJs_e), .isJns_e(isJns_e),
    .isLd_e(isLd_e), .isSt(isSt),
    .reg_wen(reg_wen), .waddr(waddr), .wdata(wdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data),
    .isJumping(isJumping), .jump_addr(jump_addr),
    .print_valid(print_valid), .print_char(print_char), .halt(halt)
  );

  int checks = 0;
  int failures = 0;
  int step_no = 0;

  // Model: mode 0 = running, 1 = squashing younger slots, 2 = halted.
  int          mode = 0;
  int          squash_left = 0;
  logic        e_retired, e_reg_wen, e_mem_wen, e_jmp, e_pv, e_halt;
  logic [15:0] e_pc, e_wdata, e_mem_addr, e_mem_data, e_jaddr;
  logic [8:0]  e_cls;   // bit 8 = sub ... bit 0 = st
  logic [3:0]  e_waddr;
  logic [7:0]  e_char;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode = 0; squash_left = 0;
    e_retired = 0; e_reg_wen = 0; e_mem_wen = 0; e_jmp = 0; e_pv = 0; e_halt = 0;
    e_pc = 0; e_wdata = 0; e_mem_addr = 0; e_mem_data = 0; e_jaddr = 0;
    e_cls = 0; e_waddr = 0; e_char = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [15:0] pc,
                            input logic [15:0] inst, input logic [15:0] va,
                            input logic [15:0] vb, input logic [15:0] vt,
                            input logic [15:0] ld);
    int op, sb, ft, imm, k;
    bit legal, wr, tk;
    logic [15:0] val;
    e_retired = 0; e_cls = 0; e_reg_wen = 0; e_mem_wen = 0; e_jmp = 0; e_pv = 0;
    if (!v || s || mode == 2) return;
    if (mode == 1) begin
      squash_left--;
      if (squash_left == 0) mode = 0;
      return;
    end
    op  = int'(inst) / 4096;
    sb  = (int'(inst) / 16) % 16;
    ft  = int'(inst) % 16;
    imm = (int'(inst) / 16) % 256;
    legal = (op == 0) || (op == 8) || (op == 9) || (op == 14 && sb < 4) || (op == 15 && sb < 2);
    e_pc = pc;
    if (!legal) begin
      e_halt = 1;
      mode = 2;
      return;
    end
    e_retired = 1;
    wr = 0; val = 0; k = 0;
    if (op == 0) begin k = 0; wr = 1; val = 16'((int'(va) - int'(vb) + 65536) % 65536); end
    if (op == 8) begin k = 1; wr = 1; val = 16'(imm >= 128 ? imm + 65280 : imm); end
    if (op == 9) begin k = 2; wr = 1; val = 16'(imm * 256 + int'(vt) % 256); end
    if (op == 15 && sb == 0) begin k = 7; wr = 1; val = ld; end
    if (op == 15 && sb == 1) begin
      k = 8; e_mem_wen = 1; e_mem_addr = va; e_mem_data = vt;
    end
    if (op == 14) begin
      k = 3 + sb;
      case (sb)
        0: tk = (va == 0);
        1: tk = (va != 0);
        2: tk = (va >= 16'h8000);
        default: tk = (va < 16'h8000);
      endcase
      e_jaddr = tk ? vt : 16'((int'(pc) + 1) % 65536);
      if (tk) begin
        e_jmp = 1; mode = 1; squash_left = FD;
      end
    end
    e_cls = 9'(9'h100 >> k);
    if (wr) begin
      e_wdata = val;
      e_waddr = 4'(ft);
      if (ft != 0) e_reg_wen = 1;
      else begin e_pv = 1; e_char = val[7:0]; end
    end
  endtask

  task automatic compare_all();
    chk("retired", 16'(retired), 16'(e_retired));
    chk("pc_e", pc_e, e_pc);
    chk("class", 16'({isSub_e, isMovl_e, isMovh_e, isJz_e, isJnz_e, isJs_e, isJns_e, isLd_e, isSt}), 16'(e_cls));
    chk("reg_wen", 16'(reg_wen), 16'(e_reg_wen));
    chk("waddr", 16'(waddr), 16'(e_waddr));
    chk("wdata", wdata, e_wdata);
    chk("mem_wen", 16'(mem_wen), 16'(e_mem_wen));
    chk("mem_addr", mem_addr, e_mem_addr);
    chk("mem_data", mem_data, e_mem_data);
    chk("isJumping", 16'(isJumping), 16'(e_jmp));
    chk("jump_addr", jump_addr, e_jaddr);
    chk("print_valid", 16'(print_valid), 16'(e_pv));
    chk("print_char", 16'(print_char), 16'(e_char));
    chk("halt", 16'(halt), 16'(e_halt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; valid_x = 1; stall = 0;
    @(posedge clk); #1;
    model_reset();
    compare_all();
    step_no++;
    $display("step %0d reset halt=%b retired=%b", step_no, halt, retired);
  endtask

  task automatic step(input bit v, input bit s, input logic [15:0] pc,
                      input logic [15:0] inst, input logic [15:0] va,
                      input logic [15:0] vb, input logic [15:0] vt,
                      input logic [15:0] ld);
    @(negedge clk);
    reset = 0; valid_x = v; stall = s;
    pc_x = pc; inst_x = inst; va_x = va; vb_x = vb; vt_x = vt; ld_data_x = ld;
    model_step(v, s, pc, inst, va, vb, vt, ld);
    @(posedge clk); #1;
    compare_all();
    step_no++;
    $display("step %0d v=%b s=%b pc=%h inst=%h -> retired=%b jump=%b halt=%b wdata=%h",
             step_no, v, s, pc, inst, retired, isJumping, halt, wdata);
  endtask

  function automatic logic [15:0] rand_inst();
    logic [3:0] a, b, t, sj;
    logic [7:0] imm;
    int r;
    r = $urandom_range(0, 99);
    a = 4'($urandom); b = 4'($urandom); t = 4'($urandom); imm = 8'($urandom);
    sj = 4'($urandom_range(0, 3));
    if (r < 15) return {4'h0, a, b, t};
    if (r < 30) return {4'h8, imm, t};
    if (r < 45) return {4'h9, imm, t};
    if (r < 65) return {4'hE, a, sj, t};
    if (r < 75) return {4'hF, a, 4'h0, t};
    if (r < 85) return {4'hF, a, 4'h1, t};
    return 16'($urandom);
  endfunction

  initial begin
    int halted_steps;
    logic [15:0] rva;

    do_reset();

    // movl r3,0x80
    step(1, 0, 16'h0010, 16'h8803, 0, 0, 0, 0);
    chk("tp_movl_wdata", wdata, 16'hFF80);
    chk("tp_movl_flag", 16'(isMovl_e), 16'h1);

    // sub r0,r1,r2 prints 'A'
    step(1, 0, 16'h0011, 16'h0120, 16'h0041, 16'h0000, 0, 0);
    chk("tp_print_char", 16'(print_char), 16'h0041);
    chk("tp_print_noreg", 16'(reg_wen), 16'h0);

    // taken jz, two squashed slots around a stall, third retires
    step(1, 0, 16'h0020, 16'hE103, 16'h0000, 0, 16'h0200, 0);
    chk("tp_jz_taken", 16'(isJumping), 16'h1);
    chk("tp_jz_target", jump_addr, 16'h0200);
    step(1, 0, 16'h0021, 16'h8105, 0, 0, 0, 0);
    chk("tp_squash1", 16'(retired), 16'h0);
    step(1, 1, 16'h0200, 16'h8206, 0, 0, 0, 0);
    step(1, 0, 16'h0200, 16'h2000, 0, 0, 0, 0);   // undefined, squashed
    chk("tp_squash_undef", 16'(halt), 16'h0);
    step(1, 0, 16'h0201, 16'h8307, 0, 0, 0, 0);
    chk("tp_after_flush", 16'(retired), 16'h1);

    // untaken jnz: falls through, no flush
    step(1, 0, 16'h0005, 16'hE113, 16'h0000, 0, 16'h0099, 0);
    chk("tp_jnz_fall", jump_addr, 16'h0006);
    step(1, 0, 16'h0006, 16'h8408, 0, 0, 0, 0);
    chk("tp_jnz_noflush", 16'(retired), 16'h1);

    // st then ld
    step(1, 0, 16'h0007, 16'hF112, 16'h1234, 0, 16'hBEEF, 0);
    chk("tp_st_addr", mem_addr, 16'h1234);
    chk("tp_st_data", mem_data, 16'hBEEF);
    step(1, 0, 16'h0008, 16'hF104, 16'h1234, 0, 0, 16'h5A5A);
    chk("tp_ld_wdata", wdata, 16'h5A5A);

    // undefined opcode halts; later slots ignored; reset recovers
    step(1, 0, 16'h0009, 16'h2000, 0, 0, 0, 0);
    chk("tp_halt", 16'(halt), 16'h1);
    step(1, 0, 16'h000A, 16'h8803, 0, 0, 0, 0);
    step(1, 0, 16'h000B, 16'h0123, 16'h0005, 16'h0001, 0, 0);
    chk("tp_halt_hold", 16'(retired), 16'h0);
    do_reset();
    chk("tp_reset_halt", 16'(halt), 16'h0);
    step(1, 0, 16'h0030, 16'h87F1, 0, 0, 0, 0);
    chk("tp_resume", 16'(retired), 16'h1);

    // random traffic
    halted_steps = 0;
    for (int i = 0; i < 400; i++) begin
      if (mode == 2) halted_steps++;
      if (halted_steps > 3 || $urandom_range(0, 59) == 0) begin
        do_reset();
        halted_steps = 0;
      end else begin
        rva = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        step($urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
             16'($urandom), rand_inst(), rva, 16'($urandom), 16'($urandom), 16'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/retire_stage.md
# retire_stage

Final pipeline stage of the 16-bit CPU: it takes each executed instruction with its operand values, decides its architectural effect, and drives the one-cycle retire outputs. Those outputs are the register-file write, the data-memory write, the taken-jump redirect, halt, and the retire/class flags consumed by the simulation logger. It also squashes the younger in-flight instructions after a taken jump, and it holds the core halted after an undefined opcode.

## Interface
- FLUSH_DEPTH, default 2: number of younger accepted instructions squashed after a taken jump (1..15).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- valid_x  in  1  execute slot holds an instruction.
- stall  in  1  pipeline stall; slot neither accepted nor counted.
- pc_x  in  16  PC of slot instruction.
- inst_x  in  16  instruction word.
- va_x, vb_x, vt_x  in  16 each  current values of r[a], r[b], r[t]; r0 reads 0.
- ld_data_x  in  16  data-memory read data at address va_x.
- retired  out  1  one instruction retired this cycle.
- pc_e  out  16  PC of retired/faulting instruction.
- isSub_e, isMovl_e, isMovh_e, isJz_e, isJnz_e, isJs_e, isJns_e, isLd_e, isSt  out  1 each  one-hot class of retired instruction.
- reg_wen  out  1  register write; waddr  out  4; wdata  out  16.
- mem_wen  out  1  memory write; mem_addr  out  16; mem_data  out  16.
- isJumping  out  1  taken jump; jump_addr  out  16  next PC of a jump (taken or not).
- print_valid  out  1  write to r0; print_char  out  8.
- halt  out  1  sticky halt.

## Operation
- Accept = valid_x & !stall & state != HALTED. Fields: op = inst[15:12], a = [11:8], b = [7:4], t = [3:0], imm8 = [11:4], sub = [7:4].
- op 0000 sub: wdata = va - vb (mod 2^16).
- op 1000 movl: wdata = sign-extended imm8.
- op 1001 movh: wdata = {imm8, vt[7:0]}.
- op 1110, sub 0/1/2/3 jz/jnz/js/jns: condition va==0 / va!=0 / va[15] / !va[15]. Target = vt. jump_addr = taken ? vt : pc_x+1.
- op 1111 sub 0 ld: wdata = ld_data_x.
- op 1111 sub 1 st: mem_addr = va, mem_data = vt, mem_wen = 1.
- Any other encoding is undefined: retired = 0, pc_e = pc_x, halt = 1.
- Register-writing classes (sub, movl, movh, ld) with t != 0: reg_wen = 1, waddr = t.
- Same classes with t == 0: reg_wen = 0, waddr = 0, wdata still valid, print_valid = 1, print_char = wdata[7:0].
- FSM RUN: an accepted taken jump goes to FLUSH with cnt = FLUSH_DEPTH. An accepted undefined instruction goes to HALTED.
- FSM FLUSH: each accepted slot is squashed (no outputs) and cnt decrements. cnt reaching 0 returns to RUN. The squashed instruction count is exactly FLUSH_DEPTH, independent of stall and bubble cycles.
- FSM HALTED: absorbing until reset. Inputs are ignored.
- Undefined instruction arriving during FLUSH is squashed, not halted.

## Timing
- All outputs registered: the instruction accepted at edge N shows its outputs during cycle N+1, for exactly one cycle.
- isJumping at N+1; the first squashed slot can be accepted at edge N+1.
- Non-accept cycle: retired, reg_wen, mem_wen, isJumping, print_valid and all class flags = 0. Data outputs hold their last value.
- Reset (including mid-FLUSH or HALTED): state RUN, cnt 0, halt 0, every output 0 on the following cycle.
- halt rises the cycle after the faulting accept and stays 1.

## Structure
- Shared package cpu_pkg holds the opcode constants (OP_SUB 4'h0, OP_MOVL 4'h8, OP_MOVH 4'h9, OP_JMP 4'hE, OP_MEM 4'hF), jump/mem sub-op constants, and the state enum {RUN, FLUSH, HALTED}.
- One sub-module, retire_decode: combinational class/condition/wdata decode. The top holds the FSM, flush counter and output registers.

## Test plan
- movl r3,0x80 (inst 0x8803) at pc 0x0010 -> cycle later retired=1, isMovl_e=1, waddr=3, wdata=0xFF80, pc_e=0x0010.
- sub r0,r1,r2 with va=0x0041, vb=0x0000 -> reg_wen=0, print_valid=1, print_char=0x41.
- jz with va=0, vt=0x0200, FLUSH_DEPTH=2; three more valid slots, with stall=1 for one cycle between them -> isJumping=1, jump_addr=0x0200; next two slots squashed; third retires.
- jnz with va=0 at pc 0x0005 -> retired=1, isJumping=0, jump_addr=0x0006, no flush.
- st with va=0x1234, vt=0xBEEF -> mem_wen=1, mem_addr=0x1234, mem_data=0xBEEF, isSt=1; then ld -> wdata=ld_data_x.
- inst 0x2000 -> halt=1, retired=0; later valid slots produce nothing; reset -> halt=0, next movl retires normally.
